// File: rtl/cat_rec_pkg.sv
// Shared types and address map for the cat recognizer load-and-run sequencer.
package cat_rec_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    W_SETUP,
    W_ACCESS,
    C_SETUP,
    C_ACCESS,
    P_SETUP,
    P_ACCESS,
    FIN
  } state_e;

  localparam int CTRL_ADDR      = 0;
  localparam int DATA_BASE      = 1;
  localparam int CTRL_START_BIT = 0;

endpackage

// File: rtl/cat_rec_sequencer.sv
// APB master that streams a word block from source memory into the cat recognizer,
// kicks the start bit, polls it until hardware clears it and reports the result.
module cat_rec_sequencer
  import cat_rec_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int Mem_Addr_Width  = 16,
  parameter int Poll_Limit      = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [Mem_Addr_Width-1:0]  src_base,
  input  logic [Amba_Addr_Depth-1:0] num_words,
  output logic                       mem_rd,
  output logic [Mem_Addr_Width-1:0]  mem_addr,
  input  logic [Amba_Word-1:0]       mem_rdata,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic [Amba_Word-1:0]       PRDATA,
  input  logic                       CatRecOut,
  output logic                       busy,
  output logic                       done,
  output logic                       result,
  output logic                       timeout
);

  localparam int AW     = Amba_Addr_Depth;
  localparam int MW     = Mem_Addr_Width;
  localparam int POLL_W = $clog2(Poll_Limit + 1);

  state_e            state_q, state_d;
  logic [MW-1:0]     src_q, src_d;
  logic [AW-1:0]     num_q, num_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [Amba_Word-1:0] cap_q, cap_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              result_q, result_d;
  logic              timeout_q, timeout_d;

  logic              more_words;
  logic [POLL_W-1:0] poll_inc;
  logic              prdata_unused;

  // Only the start bit of the status read matters.
  assign prdata_unused = ^PRDATA;

  assign more_words = ({1'b0, idx_q} + (AW + 1)'(1)) < {1'b0, num_q};
  assign poll_inc   = poll_q + POLL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      cap_q     <= '0;
      poll_q    <= '0;
      result_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      poll_q    <= poll_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    num_d     = num_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    poll_d    = poll_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = src_base;
          num_d     = num_words;
          idx_d     = '0;
          poll_d    = '0;
          result_d  = 1'b0;
          timeout_d = 1'b0;
          state_d   = (num_words == '0) ? C_SETUP : FETCH;
        end
      end
      FETCH:    state_d = W_SETUP;
      W_SETUP: begin
        cap_d   = mem_rdata;
        state_d = W_ACCESS;
      end
      W_ACCESS: begin
        if (more_words) begin
          idx_d   = idx_q + AW'(1);
          state_d = W_SETUP;
        end else begin
          state_d = C_SETUP;
        end
      end
      C_SETUP:  state_d = C_ACCESS;
      C_ACCESS: state_d = P_SETUP;
      P_SETUP:  state_d = P_ACCESS;
      P_ACCESS: begin
        // A clear start bit wins over the limit on the same poll.
        if (!PRDATA[CTRL_START_BIT]) begin
          result_d  = CatRecOut;
          timeout_d = 1'b0;
          state_d   = FIN;
        end else if (poll_inc == POLL_W'(Poll_Limit)) begin
          poll_d    = poll_inc;
          result_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          poll_d    = poll_inc;
          state_d   = P_SETUP;
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    busy     = (state_q != IDLE);
    done     = (state_q == FIN);
    result   = result_q;
    timeout  = timeout_q;
    case (state_q)
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = src_q;
      end
      W_SETUP: begin
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PADDR  = AW'(DATA_BASE) + idx_q;
        PWDATA = mem_rdata;
      end
      W_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = AW'(DATA_BASE) + idx_q;
        PWDATA  = cap_q;
        // Next word's read overlaps this ACCESS phase.
        if (more_words) begin
          mem_rd   = 1'b1;
          mem_addr = src_q + MW'(idx_q) + MW'(1);
        end
      end
      C_SETUP, C_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == C_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = AW'(CTRL_ADDR);
        PWDATA  = Amba_Word'(1) << CTRL_START_BIT;
      end
      P_SETUP, P_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == P_ACCESS);
        PADDR   = AW'(CTRL_ADDR);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cat_rec_sequencer.sv
// Self-checking bench: a cycle-indexed expectation table built from the transfer timing
// rules is compared against the DUT every cycle, plus literal checks on key results.
module tb_cat_rec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, CatRecOut;
  logic [15:0] src_base;
  logic [12:0] num_words;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [23:0] mem_rdata = '0;
  logic [12:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [23:0] PWDATA;
  logic [23:0] PRDATA = '0;
  logic        busy, done, result, timeout;

  // Second instance with a short poll limit and a status that never clears.
  logic        start_b;
  logic        mem_rd_b;
  logic [15:0] mem_addr_b;
  logic [12:0] PADDR_b;
  logic        PSEL_b, PENABLE_b, PWRITE_b;
  logic [23:0] PWDATA_b;
  logic [23:0] prdata_b;
  logic        busy_b, done_b, result_b, timeout_b;
  assign prdata_b = 24'h800001;

  cat_rec_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .num_words(num_words),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .CatRecOut(CatRecOut),
    .busy(busy), .done(done), .result(result), .timeout(timeout)
  );

  cat_rec_sequencer #(.Poll_Limit(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .src_base(16'h0000), .num_words(13'd0),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata),
    .PADDR(PADDR_b), .PSEL(PSEL_b), .PENABLE(PENABLE_b), .PWRITE(PWRITE_b), .PWDATA(PWDATA_b),
    .PRDATA(prdata_b), .CatRecOut(CatRecOut),
    .busy(busy_b), .done(done_b), .result(result_b), .timeout(timeout_b)
  );

  logic [23:0] mem [0:65535];

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    bit        mem_rd;
    bit [15:0] mem_addr;
    bit        psel;
    bit        penable;
    bit        pwrite;
    bit [12:0] paddr;
    bit [23:0] pwdata;
    bit        busy;
    bit        done;
    bit        result;
    bit        timeout;
  } exp_t;

  exp_t exp_tbl [64];
  int   exp_len;
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  bit   active = 1'b0;
  int   done_cyc;
  int   rd_seen;
  int   busy_polls = 0;
  int   prd_cnt = 0;
  bit   prev_res = 1'b0;
  bit   prev_to = 1'b0;
  logic [12:0] wr_addr_q [$];
  logic [23:0] wr_data_q [$];
  logic [15:0] mem_addr_q [$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Status responder: the first busy_polls reads see the start bit still set.
  always @(negedge clk) begin
    if (PSEL && PENABLE && !PWRITE) begin
      PRDATA = {23'h2D2D2D, (prd_cnt < busy_polls)};
      prd_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (active) begin
      e = exp_tbl[cyc];
      check_output($sformatf("busy@%0d", cyc), 32'(busy), 32'(e.busy));
      check_output($sformatf("done@%0d", cyc), 32'(done), 32'(e.done));
      check_output($sformatf("result@%0d", cyc), 32'(result), 32'(e.result));
      check_output($sformatf("timeout@%0d", cyc), 32'(timeout), 32'(e.timeout));
      check_output($sformatf("mem_rd@%0d", cyc), 32'(mem_rd), 32'(e.mem_rd));
      if (e.mem_rd)
        check_output($sformatf("mem_addr@%0d", cyc), 32'(mem_addr), 32'(e.mem_addr));
      check_output($sformatf("psel@%0d", cyc), 32'(PSEL), 32'(e.psel));
      check_output($sformatf("penable@%0d", cyc), 32'(PENABLE), 32'(e.penable));
      check_output($sformatf("pwrite@%0d", cyc), 32'(PWRITE), 32'(e.pwrite));
      check_output($sformatf("paddr@%0d", cyc), 32'(PADDR), 32'(e.paddr));
      check_output($sformatf("pwdata@%0d", cyc), 32'(PWDATA), 32'(e.pwdata));
      if (done) done_cyc = cyc;
      if (mem_rd) mem_addr_q.push_back(mem_addr);
      if (PSEL && PENABLE && PWRITE) begin
        wr_addr_q.push_back(PADDR);
        wr_data_q.push_back(PWDATA);
      end
      if (PSEL && PENABLE && !PWRITE) rd_seen++;
      cyc++;
    end
  end

  // Expected per-cycle outputs, with cycle 0 being the cycle start is held high.
  task automatic build_model(input int n, input logic [15:0] src, input int bpolls,
                             input bit cat, input int limit, input int abort_c);
    int cs, np, dn, s;
    bit to, res;
    logic [15:0] a;
    for (int i = 0; i < 64; i++) exp_tbl[i] = '{default: 0};
    cs  = (n == 0) ? 1 : 2 + 2 * n;
    to  = (bpolls >= limit);
    np  = to ? limit : bpolls + 1;
    res = to ? 1'b0 : cat;
    dn  = cs + 2 + 2 * np;
    exp_len = dn + 3;
    for (int c = 0; c < exp_len; c++) begin
      exp_tbl[c].busy    = (c >= 1 && c <= dn);
      exp_tbl[c].done    = (c == dn);
      exp_tbl[c].result  = (c == 0) ? prev_res : ((c >= dn) ? res : 1'b0);
      exp_tbl[c].timeout = (c == 0) ? prev_to  : ((c >= dn) ? to  : 1'b0);
    end
    if (n > 0) begin
      exp_tbl[1].mem_rd   = 1'b1;
      exp_tbl[1].mem_addr = src;
    end
    for (int k = 0; k < n; k++) begin
      s = 2 + 2 * k;
      a = src + 16'(k);
      for (int j = 0; j < 2; j++) begin
        exp_tbl[s+j].psel    = 1'b1;
        exp_tbl[s+j].penable = (j == 1);
        exp_tbl[s+j].pwrite  = 1'b1;
        exp_tbl[s+j].paddr   = 13'(k + 1);
        exp_tbl[s+j].pwdata  = mem[a];
      end
      if (k < n - 1) begin
        exp_tbl[s+1].mem_rd   = 1'b1;
        exp_tbl[s+1].mem_addr = src + 16'(k + 1);
      end
    end
    for (int j = 0; j < 2; j++) begin
      exp_tbl[cs+j].psel    = 1'b1;
      exp_tbl[cs+j].penable = (j == 1);
      exp_tbl[cs+j].pwrite  = 1'b1;
      exp_tbl[cs+j].pwdata  = 24'h000001;
    end
    for (int p = 0; p < np; p++) begin
      s = cs + 2 + 2 * p;
      exp_tbl[s].psel      = 1'b1;
      exp_tbl[s+1].psel    = 1'b1;
      exp_tbl[s+1].penable = 1'b1;
    end
    if (abort_c > 0) begin
      exp_len = abort_c + 8;
      for (int c = abort_c + 1; c < exp_len; c++) exp_tbl[c] = '{default: 0};
    end
  endtask

  task automatic apply_stimulus(input int n, input logic [15:0] src, input int bpolls,
                                input bit cat, input int repulse_c, input int abort_c);
    build_model(n, src, bpolls, cat, 1024, abort_c);
    busy_polls = bpolls;
    prd_cnt    = 0;
    done_cyc   = -1;
    rd_seen    = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    mem_addr_q.delete();
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = 13'(n);
    src_base  = src;
    CatRecOut = cat;
    cyc       = 0;
    active    = 1'b1;
    for (int c = 1; c < exp_len; c++) begin
      @(posedge clk); #1;
      start = (c == repulse_c);
      rst   = (c == abort_c);
      if (c == 1) begin
        src_base  = ~src;
        num_words = 13'h1ABC;
      end
    end
    @(negedge clk); #1;
    active   = 1'b0;
    prev_res = exp_tbl[exp_len-1].result;
    prev_to  = exp_tbl[exp_len-1].timeout;
  endtask

  task automatic run_timeout_check();
    int dc, rd;
    bit to, res;
    dc = -1; rd = 0; to = 1'b0; res = 1'b1;
    CatRecOut = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      @(negedge clk);
      if (PSEL_b && PENABLE_b && !PWRITE_b) rd++;
      if (done_b) begin
        dc  = c;
        to  = timeout_b;
        res = result_b;
      end
    end
    check_output("timeout_done_cycle", 32'(dc), 32'd11);
    check_output("timeout_reads", 32'(rd), 32'd4);
    check_output("timeout_flag", 32'(to), 32'd1);
    check_output("timeout_result", 32'(res), 32'd0);
    check_output("timeout_busy_after", 32'(busy_b), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 24'hA50000 ^ 24'(i);
    mem[16'h0100] = 24'h000011;
    mem[16'h0101] = 24'h000022;
    mem[16'h0102] = 24'h000033;
    mem[16'hFFFF] = 24'h0BEEF1;
    mem[16'h0000] = 24'h0C0FFE;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; CatRecOut = 1'b0;
    src_base = '0; num_words = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_psel", 32'({PSEL, PENABLE, PWRITE, mem_rd}), 32'd0);
    check_output("reset_paddr", 32'(PADDR), 32'd0);
    check_output("reset_pwdata", 32'(PWDATA), 32'd0);
    check_output("reset_result", 32'({result, timeout}), 32'd0);
    check_output("reset_b", 32'({busy_b, done_b, PSEL_b, timeout_b}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] three words, immediate completion");
    apply_stimulus(3, 16'h0100, 0, 1'b1, 0, 0);
    check_output("t1_done_cycle", 32'(done_cyc), 32'd12);
    check_output("t1_reads", 32'(rd_seen), 32'd1);
    check_output("t1_nwrites", 32'(wr_addr_q.size()), 32'd4);
    check_output("t1_wa0", 32'(wr_addr_q[0]), 32'd1);
    check_output("t1_wa1", 32'(wr_addr_q[1]), 32'd2);
    check_output("t1_wa2", 32'(wr_addr_q[2]), 32'd3);
    check_output("t1_wa3", 32'(wr_addr_q[3]), 32'd0);
    check_output("t1_wd0", 32'(wr_data_q[0]), 32'h11);
    check_output("t1_wd1", 32'(wr_data_q[1]), 32'h22);
    check_output("t1_wd2", 32'(wr_data_q[2]), 32'h33);
    check_output("t1_wd3", 32'(wr_data_q[3]), 32'h1);
    check_output("t1_result_hold", 32'({result, timeout}), 32'b10);

    $display("[TB] zero words");
    apply_stimulus(0, 16'h0200, 0, 1'b1, 0, 0);
    check_output("t2_done_cycle", 32'(done_cyc), 32'd5);
    check_output("t2_memrd_count", 32'(mem_addr_q.size()), 32'd0);
    check_output("t2_nwrites", 32'(wr_addr_q.size()), 32'd1);

    $display("[TB] four busy polls");
    apply_stimulus(1, 16'h0300, 4, 1'b0, 0, 0);
    check_output("t3_reads", 32'(rd_seen), 32'd5);
    check_output("t3_done_cycle", 32'(done_cyc), 32'd16);
    check_output("t3_result", 32'(result), 32'd0);

    $display("[TB] start re-pulsed mid transfer");
    apply_stimulus(3, 16'h0100, 1, 1'b1, 3, 0);
    check_output("t4_done_cycle", 32'(done_cyc), 32'd14);
    check_output("t4_nwrites", 32'(wr_addr_q.size()), 32'd4);

    $display("[TB] reset during third word setup");
    apply_stimulus(3, 16'h0400, 0, 1'b1, 0, 6);
    check_output("t5_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    check_output("t5_busy", 32'(busy), 32'd0);

    $display("[TB] source address wrap");
    apply_stimulus(2, 16'hFFFF, 0, 1'b1, 0, 0);
    check_output("t6_nreads", 32'(mem_addr_q.size()), 32'd2);
    check_output("t6_addr0", 32'(mem_addr_q[0]), 32'hFFFF);
    check_output("t6_addr1", 32'(mem_addr_q[1]), 32'h0000);
    check_output("t6_wd1", 32'(wr_data_q[1]), 32'h0C0FFE);
    check_output("t6_done_cycle", 32'(done_cyc), 32'd10);

    $display("[TB] poll limit timeout");
    run_timeout_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
